// File: rtl/store_sequencer.sv
// Store sequencer: sw writes directly, sh/sb do read-merge-write against the target word.
// Optional address misalignment check enabled by defining STORE_SEQ_MISALIGN_CHECK_EN.
module store_sequencer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  ss_control,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [1:0] TYPE_SW   = 2'd0;
  localparam logic [1:0] TYPE_SH   = 2'd1;
  localparam logic [1:0] TYPE_SB   = 2'd2;
  localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state;
  logic [1:0]  typ_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] mem_q;
  logic [1:0]  wait_cnt;
  logic        misaligned;

  // Merge register data into the word read back; sw ignores the old word.
  function automatic logic [31:0] merge_word(input logic [1:0] typ,
                                             input logic [31:0] old_word,
                                             input logic [31:0] data);
    case (typ)
      TYPE_SH: merge_word = {old_word[31:16], data[15:0]};
      TYPE_SB: merge_word = {old_word[31:8], data[7:0]};
      default: merge_word = data;
    endcase
  endfunction

`ifdef STORE_SEQ_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (store_type == TYPE_SW && addr[1:0] != 2'b00) misaligned = 1'b1;
    if (store_type == TYPE_SH && addr[0])            misaligned = 1'b1;
  end
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign ss_control = typ_q;
  assign mem_wdata  = (state == WRITE) ? merge_word(typ_q, mem_q, data_q) : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      typ_q    <= 2'd0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
      mem_q    <= 32'h0;
      wait_cnt <= 2'd0;
      mem_addr <= 32'h0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef STORE_SEQ_MISALIGN_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
`ifdef STORE_SEQ_MISALIGN_CHECK_EN
      err    <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          if (start) begin
            typ_q  <= store_type;
            addr_q <= addr;
            data_q <= reg_data;
            if (misaligned) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              mem_addr <= 32'h0;
`ifdef STORE_SEQ_MISALIGN_CHECK_EN
              err      <= 1'b1;
`endif
            end else if (store_type == TYPE_SW) begin
              state    <= WRITE;
              mem_wr   <= 1'b1;
              mem_addr <= addr;
              busy     <= 1'b1;
            end else if (store_type == TYPE_SH || store_type == TYPE_SB) begin
              state    <= READ;
              mem_addr <= addr;
              busy     <= 1'b1;
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              mem_addr <= 32'h0;
            end
          end else begin
            state    <= IDLE;
            busy     <= 1'b0;
            mem_addr <= 32'h0;
          end
        end
        READ: begin
          state    <= WAIT;
          wait_cnt <= WAIT_INIT;
        end
        WAIT: begin
          // Read data is valid on the last wait cycle only.
          if (wait_cnt == 2'd0) begin
            mem_q  <= mem_rdata;
            state  <= WRITE;
            mem_wr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        WRITE: begin
          state    <= DONE;
          done     <= 1'b1;
          busy     <= 1'b0;
          mem_addr <= 32'h0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_addr <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Scoreboard bench for store_sequencer: one instance at default latency, one at latency 3.
module tb_store_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int   cyc;
    logic err;
  } dn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  type_a = 2'd0, type_b = 2'd0;
  logic [31:0] addr_a = 32'h0, addr_b = 32'h0;
  logic [31:0] data_a = 32'h0, data_b = 32'h0;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] maddr_a, maddr_b, wdata_a, wdata_b;
  logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [1:0]  ss_a, ss_b;

  logic [31:0] mem [0:63];
  logic [31:0] pipe_b [0:2];

  wr_t wq_a[$], wq_b[$];
  dn_t dq_a[$], dq_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rdata_a <= mem[maddr_a[7:2]];
  always @(posedge clk) begin
    pipe_b[0] <= mem[maddr_b[7:2]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2];

  store_sequencer #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .store_type(type_a), .addr(addr_a),
    .reg_data(data_a), .mem_rdata(rdata_a), .mem_addr(maddr_a), .mem_wr(wr_a),
    .mem_wdata(wdata_a), .ss_control(ss_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  store_sequencer #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .store_type(type_b), .addr(addr_b),
    .reg_data(data_b), .mem_rdata(rdata_b), .mem_addr(maddr_b), .mem_wr(wr_b),
    .mem_wdata(wdata_b), .ss_control(ss_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wa(input logic [31:0] a, input logic [31:0] d, input int c);
    wr_t e; e.addr = a; e.data = d; e.cyc = c; wq_a.push_back(e);
  endtask
  task automatic push_da(input int c, input logic e_err);
    dn_t e; e.cyc = c; e.err = e_err; dq_a.push_back(e);
  endtask

  // Called at a falling edge; the request is accepted at the next rising edge.
  task automatic issue_a(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    start_a = 1'b1; type_a = t; addr_a = a; data_a = d;
    acc = cyc + 1;
  endtask

  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (wr_a) begin
      if (wq_a.size() == 0) chk("a_unexpected_wr", {31'b0, wr_a}, 32'h0);
      else begin
        w = wq_a.pop_front();
        chk("a_wr_addr", maddr_a, w.addr);
        chk("a_wr_data", wdata_a, w.data);
        chk("a_wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
    if (done_a) begin
      if (dq_a.size() == 0) chk("a_unexpected_done", {31'b0, done_a}, 32'h0);
      else begin
        d = dq_a.pop_front();
        chk("a_done_cycle", 32'(cyc), 32'(d.cyc));
        chk("a_done_err", {31'b0, err_a}, {31'b0, d.err});
      end
    end
  end

  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (wr_b) begin
      if (wq_b.size() == 0) chk("b_unexpected_wr", {31'b0, wr_b}, 32'h0);
      else begin
        w = wq_b.pop_front();
        chk("b_wr_addr", maddr_b, w.addr);
        chk("b_wr_data", wdata_b, w.data);
        chk("b_wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
    if (done_b) begin
      if (dq_b.size() == 0) chk("b_unexpected_done", {31'b0, done_b}, 32'h0);
      else begin
        d = dq_b.pop_front();
        chk("b_done_cycle", 32'(cyc), 32'(d.cyc));
        chk("b_done_err", {31'b0, err_b}, {31'b0, d.err});
      end
    end
  end

  initial begin
    wr_t e;
    dn_t f;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[17] = 32'h55667788;
    mem[19] = 32'hA1B2C3D4;
    mem[20] = 32'h55667788;

    repeat (3) @(negedge clk);
    chk("rst_a_wr", {31'b0, wr_a}, 32'h0);
    chk("rst_a_busy", {31'b0, busy_a}, 32'h0);
    chk("rst_a_done", {31'b0, done_a}, 32'h0);
    chk("rst_a_err", {31'b0, err_a}, 32'h0);
    chk("rst_a_ss", {30'b0, ss_a}, 32'h0);
    chk("rst_a_addr", maddr_a, 32'h0);
    chk("rst_a_wdata", wdata_a, 32'h0);
    chk("rst_b_wr", {31'b0, wr_b}, 32'h0);
    chk("rst_b_busy", {31'b0, busy_b}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // sw: write at k+1, done at k+2
    issue_a(2'd0, 32'h40, 32'hDEADBEEF);
    push_wa(32'h40, 32'hDEADBEEF, acc);
    push_da(acc + 1, 1'b0);
    @(negedge clk); start_a = 1'b0;
    chk("sw_busy", {31'b0, busy_a}, 32'h1);
    repeat (3) @(negedge clk);

    // sh: read, merge low half, write at k+3, done at k+4
    issue_a(2'd1, 32'h44, 32'h1234ABCD);
    push_wa(32'h44, 32'h5566ABCD, acc + 2);
    push_da(acc + 3, 1'b0);
    @(negedge clk); start_a = 1'b0;
    chk("sh_read_busy", {31'b0, busy_a}, 32'h1);
    chk("sh_read_addr", maddr_a, 32'h44);
    chk("sh_read_wdata", wdata_a, 32'h0);
    repeat (5) @(negedge clk);

    // no-op type: done at k+1, no write
    issue_a(2'd3, 32'h70, 32'h77777777);
    push_da(acc, 1'b0);
    @(negedge clk); start_a = 1'b0;
    chk("nop_ss", {30'b0, ss_a}, 32'h3);
    chk("nop_busy", {31'b0, busy_a}, 32'h0);
    repeat (3) @(negedge clk);

    // sb then sw back-to-back, start held through READ/WAIT/DONE
    issue_a(2'd2, 32'h4C, 32'h00000055);
    push_wa(32'h4C, 32'hA1B2C355, acc + 2);
    push_da(acc + 3, 1'b0);
    push_wa(32'h60, 32'h0BADF00D, acc + 4);
    push_da(acc + 5, 1'b0);
    @(negedge clk);
    type_a = 2'd0; addr_a = 32'h60; data_a = 32'h0BADF00D;
    repeat (4) @(negedge clk);
    start_a = 1'b0;
    chk("b2b_ss", {30'b0, ss_a}, 32'h0);
    repeat (4) @(negedge clk);

    // sh at odd address
    issue_a(2'd1, 32'h45, 32'h1234ABCD);
`ifdef STORE_SEQ_MISALIGN_CHECK_EN
    push_da(acc, 1'b1);
`else
    push_wa(32'h45, 32'h5566ABCD, acc + 2);
    push_da(acc + 3, 1'b0);
`endif
    @(negedge clk); start_a = 1'b0;
    chk("odd_sh_ss", {30'b0, ss_a}, 32'h1);
    repeat (5) @(negedge clk);

    // reset during WAIT of an sh: nothing may complete
    issue_a(2'd1, 32'h48, 32'h11112222);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    chk("mid_wait_busy", {31'b0, busy_a}, 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_wr", {31'b0, wr_a}, 32'h0);
    chk("arst_busy", {31'b0, busy_a}, 32'h0);
    chk("arst_ss", {30'b0, ss_a}, 32'h0);
    chk("arst_addr", maddr_a, 32'h0);
    chk("arst_wdata", wdata_a, 32'h0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);

    // sw after reset completes normally
    issue_a(2'd0, 32'h64, 32'hCAFEF00D);
    push_wa(32'h64, 32'hCAFEF00D, acc);
    push_da(acc + 1, 1'b0);
    @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);

    // sb on the latency-3 instance: write at k+5, done at k+6
    start_b = 1'b1; type_b = 2'd2; addr_b = 32'h50; data_b = 32'hFFFFFF9A;
    acc = cyc + 1;
    e.addr = 32'h50; e.data = 32'h5566779A; e.cyc = acc + 4; wq_b.push_back(e);
    f.cyc = acc + 5; f.err = 1'b0; dq_b.push_back(f);
    @(negedge clk); start_b = 1'b0;
    chk("b_read_addr", maddr_b, 32'h50);
    repeat (8) @(negedge clk);

    chk("a_wq_empty", 32'(wq_a.size()), 32'h0);
    chk("a_dq_empty", 32'(dq_a.size()), 32'h0);
    chk("b_wq_empty", 32'(wq_b.size()), 32'h0);
    chk("b_dq_empty", 32'(dq_b.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
